// File: rtl/hf_subcarrier_demod.sv
// ISO14443-A reader core: edge-detect filter, per-window load-modulation decision, SSP word serialiser, carrier enable.
// Optional macro HF_DEMOD_HYST_EN: two-window hysteresis on the modulation decision.
module hf_subcarrier_demod #(
  parameter int unsigned ADC_W         = 8,
  parameter int unsigned SC_PERIOD     = 16,
  parameter int unsigned BITS_PER_WORD = 8,
  parameter int unsigned THRESH_W      = 8
) (
  input  logic                         osc_clk,
  input  logic                         rst_n,
  input  logic [ADC_W-1:0]             adc_d,
  input  logic [2:0]                   mode,
  input  logic [THRESH_W-1:0]          threshold,
  input  logic [$clog2(SC_PERIOD)-1:0] phase_adj,
  input  logic                         ssp_dout,
  output logic                         ssp_clk,
  output logic                         ssp_frame,
  output logic                         ssp_din,
  output logic                         carrier_en,
  output logic                         curbit
);

  localparam int unsigned SUB_W = $clog2(SC_PERIOD);
  localparam int unsigned CNT_W = $clog2(SC_PERIOD * BITS_PER_WORD);
  localparam int unsigned IDX_W = CNT_W - SUB_W;
  localparam int unsigned F_W   = ADC_W + 3;
  localparam int unsigned HALF  = SC_PERIOD / 2;

  localparam logic [2:0] MODE_READER_LISTEN = 3'b011;
  localparam logic [2:0] MODE_READER_MOD    = 3'b100;

  localparam logic signed [F_W-1:0] F_ZERO = '0;

  logic [CNT_W-1:0]         cnt;
  logic [SUB_W-1:0]         sub;
  logic [IDX_W-1:0]         bit_idx;
  logic [ADC_W-1:0]         p1, p2, p3, p4;
  logic [2:0]               fill_cnt;
  logic signed [F_W-1:0]    x_e, p1_e, p3_e, p4_e;
  logic signed [F_W-1:0]    f_raw, f;
  logic signed [F_W-1:0]    fall_max, rise_min, thr_s;
  logic                     window_end, det, decision;
  logic [BITS_PER_WORD-1:0] acc, tx_sr, word_now, payload, word_sel;
  logic [2:0]               mode_q;
  logic                     mod_q, run_q;

  assign sub     = cnt[SUB_W-1:0];
  assign bit_idx = cnt[CNT_W-1:SUB_W];

  // Free-running word counter and 4-deep sample history
  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      p1       <= '0;
      p2       <= '0;
      p3       <= '0;
      p4       <= '0;
      fill_cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      p1  <= adc_d;
      p2  <= p1;
      p3  <= p2;
      p4  <= p3;
      if (fill_cnt < 3'd4) begin
        fill_cnt <= fill_cnt + 3'd1;
      end
    end
  end

  // Gaussian-derivative edge filter; output held at zero until history is valid
  assign x_e  = $signed(F_W'(adc_d));
  assign p1_e = $signed(F_W'(p1));
  assign p3_e = $signed(F_W'(p3));
  assign p4_e = $signed(F_W'(p4));

  always_comb begin
    f_raw = ((p4_e <<< 1) + p3_e) - ((x_e <<< 1) + p1_e);
    f     = (fill_cnt < 3'd4) ? F_ZERO : f_raw;
  end

  assign window_end = (sub == phase_adj);
  assign thr_s      = $signed(F_W'(threshold));
  assign det        = (fall_max > thr_s) && (rise_min < -thr_s);

`ifdef HF_DEMOD_HYST_EN
  logic det_prev;

  // Decision only moves after two agreeing windows
  always_comb begin
    decision = curbit;
    if (det && det_prev) begin
      decision = 1'b1;
    end else if (!det && !det_prev) begin
      decision = 1'b0;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      det_prev <= 1'b0;
    end else if (window_end) begin
      det_prev <= det;
    end
  end
`else
  assign decision = det;
`endif

  // Peak tracking per window; the compare cycle's own sample is discarded
  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      fall_max <= '0;
      rise_min <= '0;
      curbit   <= 1'b0;
      acc      <= '0;
    end else if (window_end) begin
      fall_max <= '0;
      rise_min <= '0;
      curbit   <= decision;
      acc      <= {acc[BITS_PER_WORD-2:0], decision};
    end else begin
      if ((f > F_ZERO) && (f > fall_max)) begin
        fall_max <= f;
      end
      if ((f <= F_ZERO) && (f < rise_min)) begin
        rise_min <= f;
      end
    end
  end

  // At the word boundary the fresh word is sent straight from acc, since tx_sr loads on that same edge
  assign word_now = (mode == MODE_READER_LISTEN) ? acc : '0;
  assign payload  = (mode_q == MODE_READER_LISTEN) ? tx_sr : '0;
  assign word_sel = (cnt == '0) ? word_now : payload;

  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      tx_sr     <= '0;
      mode_q    <= '0;
      ssp_clk   <= 1'b0;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b0;
    end else begin
      if (cnt == '0) begin
        tx_sr  <= acc;
        mode_q <= mode;
      end
      if (sub == '0) begin
        ssp_clk <= 1'b1;
        ssp_din <= word_sel[~bit_idx];
      end else if (sub == SUB_W'(HALF)) begin
        ssp_clk <= 1'b0;
      end
      if (cnt == CNT_W'(HALF - 1)) begin
        ssp_frame <= 1'b1;
      end else if (cnt == CNT_W'(SC_PERIOD + HALF - 1)) begin
        ssp_frame <= 1'b0;
      end
    end
  end

  // Carrier follows live mode so pauses are not delayed by word sampling
  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      mod_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      mod_q <= ssp_dout;
      run_q <= 1'b1;
    end
  end

  assign carrier_en = run_q & (((mode == MODE_READER_MOD) & ~mod_q) | (mode == MODE_READER_LISTEN));

endmodule

// File: tb/tb_hf_subcarrier_demod.sv
// Bench for hf_subcarrier_demod: directed scenarios plus randomized traffic against a sample-level reference model.
module tb_hf_subcarrier_demod;

  localparam int SC   = 16;
  localparam int BPW  = 8;
  localparam int NCNT = SC * BPW;
  localparam logic [2:0] M_RL = 3'b011;
  localparam logic [2:0] M_RM = 3'b100;

  logic       osc_clk = 1'b0;
  logic       rst_n;
  logic [7:0] adc_d;
  logic [2:0] mode;
  logic [7:0] threshold;
  logic [3:0] phase_adj;
  logic       ssp_dout;
  logic       ssp_clk, ssp_frame, ssp_din, carrier_en, curbit;

  hf_subcarrier_demod dut (
    .osc_clk   (osc_clk),
    .rst_n     (rst_n),
    .adc_d     (adc_d),
    .mode      (mode),
    .threshold (threshold),
    .phase_adj (phase_adj),
    .ssp_dout  (ssp_dout),
    .ssp_clk   (ssp_clk),
    .ssp_frame (ssp_frame),
    .ssp_din   (ssp_din),
    .carrier_en(carrier_en),
    .curbit    (curbit)
  );

  always #5 osc_clk = ~osc_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int         hist[$];
  int         mcnt, fmax, fmin;
  bit         mcur, mprev, mrun, mmod, exp_clk, exp_frame;
  bit         dq[$];
  logic [7:0] exp_words[$];
  // ARM-side word capture
  bit         prev_clk, capturing;
  int         cap_n, words_seen, sq_ph;
  logic [7:0] cap, last_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    dq.delete();
    for (int i = 0; i < BPW; i++) dq.push_back(1'b0);
    exp_words.delete();
    mcnt = 0; fmax = 0; fmin = 0;
    mcur = 0; mprev = 0; mrun = 0; mmod = 0;
    exp_clk = 0; exp_frame = 0;
    prev_clk = 0; capturing = 0; cap_n = 0;
  endtask

  // Applies the sampling-edge rules to the inputs present at this edge
  task automatic model_edge();
    int f, x, sub, thr;
    bit det;
    logic [7:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    x   = int'(adc_d);
    thr = int'(threshold);
    sub = mcnt % SC;
    f   = 0;
    if (hist.size() >= 4) f = 2 * hist[0] + hist[1] - 2 * x - hist[3];
    if (mcnt == 0) begin
      for (int i = 0; i < BPW; i++) w[BPW-1-i] = dq[i];
      exp_words.push_back((mode == M_RL) ? w : 8'h00);
    end
    if (sub == int'(phase_adj)) begin
      det = (fmax > thr) && (fmin < -thr);
`ifdef HF_DEMOD_HYST_EN
      if (det && mprev) mcur = 1;
      else if (!det && !mprev) mcur = 0;
      mprev = det;
`else
      mcur = det;
`endif
      dq.push_back(mcur);
      void'(dq.pop_front());
      fmax = 0;
      fmin = 0;
    end else begin
      if (f > 0 && f > fmax) fmax = f;
      if (f <= 0 && f < fmin) fmin = f;
    end
    exp_clk   = (sub < SC / 2);
    exp_frame = (mcnt >= SC / 2 - 1) && (mcnt <= SC + SC / 2 - 2);
    hist.push_back(x);
    if (hist.size() > 4) void'(hist.pop_front());
    mcnt = (mcnt + 1) % NCNT;
    mmod = ssp_dout;
    mrun = 1;
  endtask

  task automatic observe();
    logic [7:0] w;
    chk("curbit", 32'(curbit), 32'(mcur));
    chk("ssp_clk", 32'(ssp_clk), 32'(exp_clk));
    chk("ssp_frame", 32'(ssp_frame), 32'(exp_frame));
    chk("carrier_en", 32'(carrier_en),
        32'(mrun && (((mode == M_RM) && !mmod) || (mode == M_RL))));
    if (prev_clk && !ssp_clk) begin
      if (ssp_frame) begin
        capturing = 1;
        cap_n = 0;
      end
      if (capturing) begin
        cap = {cap[6:0], ssp_din};
        cap_n++;
        if (cap_n == BPW) begin
          capturing = 0;
          words_seen++;
          last_word = cap;
          chk("word_queue_depth", 32'(exp_words.size()), 32'd1);
          if (exp_words.size() > 0) begin
            w = exp_words.pop_front();
            chk("ssp_word", 32'(cap), 32'(w));
          end
        end
      end
    end
    prev_clk = ssp_clk;
  endtask

  task automatic step();
    @(posedge osc_clk);
    model_edge();
    #1;
    observe();
  endtask

  // Square wave, half period 8 samples
  task automatic sq(input int lo, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      adc_d = 8'(((sq_ph / 8) % 2 == 0) ? lo : hi);
      sq_ph++;
      step();
    end
  endtask

  task automatic wait_sub(input int s);
    step();
    for (int k = 0; k < SC && (mcnt % SC) != s; k++) step();
  endtask

  task automatic burst();
    adc_d = 8'd100;
    repeat (6) step();
    adc_d = 8'd128;
  endtask

  initial begin
    logic [31:0] exp1;
    int amp, per, noise;
    model_reset();
    words_seen = 0; sq_ph = 0; cap = '0; last_word = '0;
    rst_n = 0; adc_d = 0; mode = M_RL; threshold = 8'd5; phase_adj = 4'd4; ssp_dout = 0;

    for (int i = 0; i < 3; i++) begin
      adc_d = (i % 2 == 1) ? 8'd255 : 8'd0;
      step();
    end
    chk("rst_ssp_clk", 32'(ssp_clk), 32'd0);
    chk("rst_ssp_frame", 32'(ssp_frame), 32'd0);
    chk("rst_ssp_din", 32'(ssp_din), 32'd0);
    chk("rst_carrier_en", 32'(carrier_en), 32'd0);
    chk("rst_curbit", 32'(curbit), 32'd0);

    rst_n = 1;
    adc_d = 8'd128;
    repeat (4) step();
    repeat (3 * NCNT) step();
    chk("flat_word", 32'(last_word), 32'h00);
    chk("flat_curbit", 32'(curbit), 32'd0);

    sq(100, 150, 3 * NCNT);
    chk("sq_curbit", 32'(curbit), 32'd1);
    chk("sq_word", 32'(last_word), 32'hFF);

    threshold = 8'd60;
    sq(100, 120, 2 * NCNT);
    chk("thr_equal_curbit", 32'(curbit), 32'd0);
    threshold = 8'd59;
    sq(100, 120, 2 * NCNT);
    chk("thr_minus1_curbit", 32'(curbit), 32'd1);

    threshold = 8'd5;
    sq(100, 150, NCNT);
    for (int k = 0; k < NCNT && mcnt != 60; k++) sq(100, 150, 1);
    mode = M_RM;
    sq(100, 150, 3 * NCNT);
    chk("rm_word", 32'(last_word), 32'h00);
    ssp_dout = 0;
    step();
    chk("rm_carrier_on", 32'(carrier_en), 32'd1);
    ssp_dout = 1;
    step();
    chk("rm_carrier_pause", 32'(carrier_en), 32'd0);
    ssp_dout = 0;
    mode = M_RL;

    adc_d = 8'd128;
    repeat (2 * NCNT) step();
    chk("hyst_idle_curbit", 32'(curbit), 32'd0);
    wait_sub(5);
    burst();
    wait_sub(5);
`ifdef HF_DEMOD_HYST_EN
    exp1 = 32'd0;
`else
    exp1 = 32'd1;
`endif
    chk("one_window_curbit", 32'(curbit), exp1);
    repeat (2) wait_sub(5);
    burst();
    wait_sub(5);
    burst();
    wait_sub(5);
    chk("two_window_curbit", 32'(curbit), 32'd1);

    for (int blk = 0; blk < 12; blk++) begin
      threshold = 8'($urandom_range(0, 120));
      phase_adj = 4'($urandom_range(0, 15));
      mode      = 3'($urandom_range(0, 4));
      amp       = int'($urandom_range(0, 60));
      per       = 2 * int'($urandom_range(2, 12));
      noise     = int'($urandom_range(0, 10));
      for (int i = 0; i < NCNT + 37; i++) begin
        adc_d = 8'(100 + (((i / (per / 2)) % 2 == 1) ? amp : 0) + int'($urandom_range(0, noise)));
        ssp_dout = 1'($urandom_range(0, 1));
        if (blk == 6 && i == 50) rst_n = 0;
        if (blk == 6 && i == 53) rst_n = 1;
        step();
      end
    end
    chk("words_seen", 32'(words_seen > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
